// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback path: default widths,
// the hard-wired zero register address and the writeback requester encoding.
package regfile_pkg;

    localparam int ADDR_SIZE_DEF = 5;
    localparam int WORD_SIZE_DEF = 64;
    localparam int X0_ADDR       = 0;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } requester_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; remembers the last winner so that a
// simultaneous request goes to the other side.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic stall,
    input  logic req_alu,
    input  logic req_lsu,
    output logic grant_alu,
    output logic grant_lsu
);

    requester_t last_grant;
    logic       enable;

    assign enable    = !rst && !stall;
    assign grant_alu = enable && req_alu && (!req_lsu || last_grant == REQ_LSU);
    assign grant_lsu = enable && req_lsu && (!req_alu || last_grant == REQ_ALU);

    // After reset the pointer names the LSU, so the ALU wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= REQ_LSU;
        end else if (grant_alu) begin
            last_grant <= REQ_ALU;
        end else if (grant_lsu) begin
            last_grant <= REQ_LSU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single reg_file write port between the ALU and LSU writeback paths.
// Define WB_BYPASS_EN to forward the in-flight write onto the read data outputs.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_stall,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_SIZE-1:0] alu_addr,
    input  logic [WORD_SIZE-1:0] alu_data,
    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [ADDR_SIZE-1:0] lsu_addr,
    input  logic [WORD_SIZE-1:0] lsu_data,
    output logic                 RegWrite,
    output logic [ADDR_SIZE-1:0] wr_add,
    output logic [WORD_SIZE-1:0] wr_data,
    input  logic [ADDR_SIZE-1:0] rd_addr1,
    input  logic [ADDR_SIZE-1:0] rd_addr2,
    input  logic [WORD_SIZE-1:0] rf_data1,
    input  logic [WORD_SIZE-1:0] rf_data2,
    output logic [WORD_SIZE-1:0] fwd_data1,
    output logic [WORD_SIZE-1:0] fwd_data2,
    output logic [CNT_W-1:0]     conflict_cnt
);

    localparam logic [ADDR_SIZE-1:0] ZERO_REG = ADDR_SIZE'(X0_ADDR);

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .stall     (wb_stall),
        .req_alu   (alu_valid),
        .req_lsu   (lsu_valid),
        .grant_alu (alu_ready),
        .grant_lsu (lsu_ready)
    );

    // Writes aimed at x0 are accepted from the requester but never reach reg_file.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite     <= 1'b0;
            wr_add       <= '0;
            wr_data      <= '0;
            conflict_cnt <= '0;
        end else begin
            RegWrite <= (alu_ready && alu_addr != ZERO_REG) ||
                        (lsu_ready && lsu_addr != ZERO_REG);
            if (alu_ready) begin
                wr_add  <= alu_addr;
                wr_data <= alu_data;
            end else if (lsu_ready) begin
                wr_add  <= lsu_addr;
                wr_data <= lsu_data;
            end
            if (alu_valid && lsu_valid && !wb_stall && conflict_cnt != {CNT_W{1'b1}}) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        fwd_data1 = rf_data1;
        fwd_data2 = rf_data2;
        if (RegWrite && wr_add == rd_addr1 && rd_addr1 != ZERO_REG) begin
            fwd_data1 = wr_data;
        end
        if (RegWrite && wr_add == rd_addr2 && rd_addr2 != ZERO_REG) begin
            fwd_data2 = wr_data;
        end
    end
`else
    logic unused_rd_addr;

    assign unused_rd_addr = ^{rd_addr1, rd_addr2};
    assign fwd_data1      = rf_data1;
    assign fwd_data2      = rf_data2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; follows WB_BYPASS_EN
// so the forwarding expectation matches the build under test.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_stall;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_addr;
    logic [63:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_addr;
    logic [63:0] lsu_data;
    logic        RegWrite;
    logic [4:0]  wr_add;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [63:0] rf_data1;
    logic [63:0] rf_data2;
    logic [63:0] fwd_data1;
    logic [63:0] fwd_data2;
    logic [15:0] conflict_cnt;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .wb_stall     (wb_stall),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_addr     (lsu_addr),
        .lsu_data     (lsu_data),
        .RegWrite     (RegWrite),
        .wr_add       (wr_add),
        .wr_data      (wr_data),
        .rd_addr1     (rd_addr1),
        .rd_addr2     (rd_addr2),
        .rf_data1     (rf_data1),
        .rf_data2     (rf_data2),
        .fwd_data1    (fwd_data1),
        .fwd_data2    (fwd_data2),
        .conflict_cnt (conflict_cnt)
    );

    task automatic apply_stimulus(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                                  input logic lv, input logic [4:0] la, input logic [63:0] ld,
                                  input logic st);
        alu_valid = av;
        alu_addr  = aa;
        alu_data  = ad;
        lsu_valid = lv;
        lsu_addr  = la;
        lsu_data  = ld;
        wb_stall  = st;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        rd_addr1 = '0;
        rd_addr2 = '0;
        rf_data1 = '0;
        rf_data2 = '0;
        apply_stimulus(1'b1, 5'd4, 64'd1, 1'b0, 5'd0, 64'd0, 1'b0);
        check_output("ready_in_reset", {62'd0, alu_ready, lsu_ready}, 64'd0);
        tick();
        tick();
        check_output("reset_regwrite", RegWrite, 1'b0);
        check_output("reset_wr_add", wr_add, 5'd0);
        check_output("reset_wr_data", wr_data, 64'd0);
        check_output("reset_cnt", conflict_cnt, 16'd0);

        // Single ALU request
        rst = 1'b0;
        apply_stimulus(1'b1, 5'd5, 64'd464, 1'b0, 5'd0, 64'd0, 1'b0);
        check_output("alu_only_ready", {62'd0, alu_ready, lsu_ready}, 64'b10);
        tick();
        check_output("alu_only_regwrite", RegWrite, 1'b1);
        check_output("alu_only_wr_add", wr_add, 5'd5);
        check_output("alu_only_wr_data", wr_data, 64'd464);

        // Single LSU request leaves the pointer on the LSU
        apply_stimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h77, 1'b0);
        check_output("lsu_only_ready", {62'd0, alu_ready, lsu_ready}, 64'b01);
        tick();
        check_output("lsu_only_wr_add", wr_add, 5'd9);
        check_output("lsu_only_wr_data", wr_data, 64'h77);

        // Four back-to-back conflicts alternate ALU, LSU, ALU, LSU
        apply_stimulus(1'b1, 5'd3, 64'd433, 1'b1, 5'd17, 64'd433, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_output("rr_ready", {62'd0, alu_ready, lsu_ready}, (i % 2 == 0) ? 64'b10 : 64'b01);
            tick();
            check_output("rr_regwrite", RegWrite, 1'b1);
            check_output("rr_wr_add", wr_add, (i % 2 == 0) ? 64'd3 : 64'd17);
        end
        check_output("rr_cnt", conflict_cnt, 16'd4);

        // ALU write to x0 is accepted but suppressed
        apply_stimulus(1'b1, 5'd0, 64'd99, 1'b0, 5'd0, 64'd0, 1'b0);
        check_output("x0_ready", alu_ready, 1'b1);
        tick();
        check_output("x0_regwrite", RegWrite, 1'b0);

        // Stall after a grant: pending write completes, no new grant, no count
        apply_stimulus(1'b1, 5'd7, 64'h55, 1'b0, 5'd0, 64'd0, 1'b0);
        check_output("pre_stall_ready", alu_ready, 1'b1);
        tick();
        apply_stimulus(1'b1, 5'd3, 64'd1, 1'b1, 5'd17, 64'd2, 1'b1);
        check_output("stall_regwrite", RegWrite, 1'b1);
        check_output("stall_wr_add", wr_add, 5'd7);
        check_output("stall_wr_data", wr_data, 64'h55);
        check_output("stall_ready", {62'd0, alu_ready, lsu_ready}, 64'd0);
        tick();
        check_output("stall_cnt", conflict_cnt, 16'd4);
        check_output("stall_regwrite_after", RegWrite, 1'b0);

        // Reset right after an ALU grant: entry dropped, pointer back to LSU
        apply_stimulus(1'b1, 5'd12, 64'habc, 1'b0, 5'd0, 64'd0, 1'b0);
        check_output("pre_reset_ready", alu_ready, 1'b1);
        rst = 1'b1;
        tick();
        check_output("midreset_regwrite", RegWrite, 1'b0);
        check_output("midreset_cnt", conflict_cnt, 16'd0);
        rst = 1'b0;
        apply_stimulus(1'b1, 5'd3, 64'd433, 1'b1, 5'd17, 64'd433, 1'b0);
        check_output("post_reset_ready", {62'd0, alu_ready, lsu_ready}, 64'b10);
        tick();
        check_output("post_reset_wr_add", wr_add, 5'd3);
        check_output("post_reset_cnt", conflict_cnt, 16'd1);

        // Forwarding of the in-flight write
        apply_stimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd17, 64'd433, 1'b0);
        tick();
        apply_stimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
        rd_addr1 = 5'd17;
        rf_data1 = 64'd0;
        rd_addr2 = 5'd4;
        rf_data2 = 64'd21;
        #1;
        check_output("bypass_regwrite", RegWrite, 1'b1);
`ifdef WB_BYPASS_EN
        check_output("bypass_fwd1", fwd_data1, 64'd433);
`else
        check_output("bypass_fwd1", fwd_data1, 64'd0);
`endif
        check_output("bypass_fwd2", fwd_data2, 64'd21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
